snare_trigger_sequencer: RTL and testbench
==========================================

# snare_trigger_sequencer

Generates the `snare_trigger` level consumed by the APU snare voice. Game-logic hit requests and a built-in 16-step drum pattern are merged into a small pending-hit counter. Triggers are issued one at a time: each is held high for a fixed number of scanlines, then followed by a guard gap long enough for the APU snare burst (6000 lines) to finish and re-arm. Sits between game logic / video timing and the APU, on the same clock and `pix_x`/`frame_end` timing.

## Interface

- `HOLD_LINES`, 4: scanlines `snare_trigger` stays high per hit; ≥1.
- `GAP_LINES`, 6008: scanlines from trigger rise to next-hit eligibility; > `HOLD_LINES`, ≤16383.
- `QUEUE_DEPTH`, 4: max pending hits; 1..7.
- `BEAT_FRAMES`, 15: frames per pattern step; ≥1.
- `PATTERN`, 16'h1111: step n hits when `PATTERN[n]`=1; step 0 first.
- `clk` in 1: pixel clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `event_strobe` in 1: one-cycle hit request from game logic.
- `pattern_enable` in 1: level; enables pattern playback.
- `frame_end` in 1: one-cycle pulse per frame.
- `pix_x` in 10: current pixel column; a cycle with `pix_x`==0 counts as one scanline.
- `snare_trigger` out 1: registered trigger level to the APU.
- `busy` out 1: state≠IDLE.
- `queue_count` out 3: pending hits.
- `event_dropped` out 1: one-cycle pulse when ≥1 request is lost to saturation.

## Operation

- Reset: state IDLE, `snare_trigger`=0, `busy`=0, `queue_count`=0, `event_dropped`=0, line counter, frame divider and step index = 0. Applies mid-HOLD/GAP; the trigger drops on the next cycle.
- Pattern engine:
  - `pattern_enable`=0 holds the 4-bit step index and the frame divider at 0.
  - When enabled, on each `frame_end`:
    - If the divider is 0: request a hit when `PATTERN[step]`=1, then advance the step (mod 16, 15→0 wrap).
    - Divider increments and wraps at `BEAT_FRAMES`−1→0.
  - The first `frame_end` after enable evaluates step 0.
- Pending counter:
  - Each cycle: next = count + inc − dec, where inc = `event_strobe` + pattern request (0..2) and dec = 1 on an IDLE→HOLD transition.
  - Result saturates at `QUEUE_DEPTH`. If any increment is discarded, `event_dropped`=1 for the next cycle.
  - A simultaneous strobe and pattern request count as two hits.
- FSM (14-bit line counter):
  - IDLE: if `queue_count`>0 → HOLD. Set `snare_trigger`=1, clear the line counter, decrement the count.
  - HOLD: line counter +1 on each `pix_x`==0 cycle. When it reaches `HOLD_LINES` → GAP, `snare_trigger`=0.
  - GAP: keep counting lines. When it reaches `GAP_LINES` → IDLE.
- The rise-to-rise spacing between consecutive triggers is always ≥ `GAP_LINES` scanlines.
- Requests arriving in HOLD/GAP are queued, never dropped unless saturated.

## Timing

- All outputs are registered.
- `event_strobe` sampled at edge t (IDLE, empty queue): `queue_count`=1 after t; `snare_trigger`=1 and `busy`=1 after t+1; `queue_count` back to 0 after t+1.
- Trigger fall: the edge where the line counter reaches `HOLD_LINES`. With the defaults this is the 4th `pix_x`==0 cycle after the rise; a `pix_x`==0 in the entering cycle does not count.
- IDLE re-entry: the edge where the counter reaches `GAP_LINES`. A waiting hit raises the trigger one cycle later.
- `frame_end` coincident with `pix_x`==0: both are processed in the same cycle.
- `event_dropped` asserts the cycle after the saturating increment.

## Test plan

- **Single hit.** Reset, then one `event_strobe`; `pix_x` sweeps 0..799.
  - Trigger rises 2 cycles after the strobe.
  - Trigger falls after 4 lines; `busy` drops after 6008 lines.
  - `queue_count` ends at 0.
- **Back-to-back.** Three strobes 10 cycles apart.
  - `queue_count` peaks at 2.
  - Three trigger pulses, rises exactly 6008 lines + 1 cycle apart.
- **Overflow.** Six strobes on consecutive cycles while in GAP, with `queue_count`=0 beforehand.
  - `queue_count` saturates at 4.
  - `event_dropped` pulses twice.
  - Four further triggers follow.
- **Pattern.** `pattern_enable`=1, `PATTERN`=16'h1111, `BEAT_FRAMES`=15, frames of 525 lines.
  - Requests on the frame_end pulses numbered 1, 61, 121, 181, 241 (step 0 wraps).
  - Each produces one trigger.
- **Simultaneous sources.** `event_strobe` in the same cycle as a step-0 `frame_end`, queue empty.
  - `queue_count`→2 next cycle, then 1 after entering HOLD.
  - Two triggers result.
- **Reset mid-operation.** Assert `reset` for 1 cycle during HOLD with `queue_count`=3.
  - Next cycle: `snare_trigger`=0, `busy`=0, `queue_count`=0.
  - No trigger without a new request.

Source files
------------

// File: rtl/snare_trigger_sequencer_if.sv
// Signal bundle between game logic / video timing and the snare trigger sequencer.
// The master side drives requests and timing; the slave side returns the trigger and status.
interface snare_trigger_sequencer_if;
  logic       event_strobe;
  logic       pattern_enable;
  logic       frame_end;
  logic [9:0] pix_x;
  logic       snare_trigger;
  logic       busy;
  logic [2:0] queue_count;
  logic       event_dropped;

  modport master (
    output event_strobe, pattern_enable, frame_end, pix_x,
    input  snare_trigger, busy, queue_count, event_dropped
  );

  modport slave (
    input  event_strobe, pattern_enable, frame_end, pix_x,
    output snare_trigger, busy, queue_count, event_dropped
  );
endinterface

// File: rtl/snare_trigger_sequencer.sv
// Merges game hit requests and a 16-step drum pattern into a pending-hit counter, then
// issues snare triggers one at a time with a hold time and a guard gap measured in scanlines.
module snare_trigger_sequencer #(
  parameter int          HOLD_LINES  = 4,
  parameter int          GAP_LINES   = 6008,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          BEAT_FRAMES = 15,
  parameter logic [15:0] PATTERN     = 16'h1111
) (
  input  logic clk,
  input  logic reset,
  snare_trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int             DIV_W    = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_FRAMES - 1);
  localparam logic [13:0]    HOLD_END = 14'(HOLD_LINES);
  localparam logic [13:0]    GAP_END  = 14'(GAP_LINES);
  localparam logic [3:0]     DEPTH    = 4'(QUEUE_DEPTH);

  state_t           state, state_next;
  logic [13:0]      line_cnt, line_cnt_next, line_inc;
  logic [3:0]       step_idx;
  logic [DIV_W-1:0] frame_div;
  logic             line_tick;
  logic             pattern_req;
  logic             take_hit;
  logic [1:0]       inc;
  logic [3:0]       sum;
  logic [2:0]       queue_cnt, queue_cnt_next;
  logic             drop_next;
  logic             trigger_q, busy_q, dropped_q;

  assign line_tick   = (bus.pix_x == 10'd0);
  assign line_inc    = line_cnt + 14'd1;
  assign pattern_req = bus.pattern_enable && bus.frame_end && (frame_div == '0)
                       && PATTERN[step_idx];

  // Beat clock: the divider gates which frame_end pulses evaluate a pattern step.
  always_ff @(posedge clk) begin
    if (reset || !bus.pattern_enable) begin
      step_idx  <= 4'd0;
      frame_div <= '0;
    end else if (bus.frame_end) begin
      if (frame_div == '0)
        step_idx <= step_idx + 4'd1;
      frame_div <= (frame_div == DIV_LAST) ? '0 : frame_div + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    line_cnt_next = line_cnt;
    take_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (queue_cnt != 3'd0) begin
          state_next    = HOLD;
          line_cnt_next = 14'd0;
          take_hit      = 1'b1;
        end
      end
      HOLD: begin
        if (line_tick) begin
          line_cnt_next = line_inc;
          if (line_inc == HOLD_END)
            state_next = GAP;
        end
      end
      GAP: begin
        if (line_tick) begin
          line_cnt_next = line_inc;
          if (line_inc == GAP_END)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A strobe and a pattern step in the same cycle are two separate hits.
  always_comb begin
    inc       = {1'b0, bus.event_strobe} + {1'b0, pattern_req};
    sum       = {1'b0, queue_cnt} + {2'b00, inc} - {3'b000, take_hit};
    drop_next = 1'b0;
    if (sum > DEPTH) begin
      queue_cnt_next = DEPTH[2:0];
      drop_next      = 1'b1;
    end else begin
      queue_cnt_next = sum[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      line_cnt  <= 14'd0;
      queue_cnt <= 3'd0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_next;
      line_cnt  <= line_cnt_next;
      queue_cnt <= queue_cnt_next;
      trigger_q <= (state_next == HOLD);
      busy_q    <= (state_next != IDLE);
      dropped_q <= drop_next;
    end
  end

  assign bus.snare_trigger = trigger_q;
  assign bus.busy          = busy_q;
  assign bus.queue_count   = queue_cnt;
  assign bus.event_dropped = dropped_q;

endmodule

// File: tb/tb_snare_trigger_sequencer.sv
// Directed bench for the snare trigger sequencer using short 8-pixel lines and a
// shortened guard gap so whole trigger cycles fit in a brief run.
module tb_snare_trigger_sequencer;

  localparam int          HOLD_LINES  = 4;
  localparam int          GAP_LINES   = 12;
  localparam int          QUEUE_DEPTH = 4;
  localparam int          BEAT_FRAMES = 3;
  localparam logic [15:0] PATTERN     = 16'h1111;
  localparam int          LINE_LEN    = 8;
  localparam int          WAIT_BUDGET = 3000;

  logic clk;
  logic reset;
  int   checks_total;
  int   checks_passed;
  int   line_count;
  int   rises;
  int   drops;
  logic trig_prev;

  snare_trigger_sequencer_if bus ();

  snare_trigger_sequencer #(
    .HOLD_LINES  (HOLD_LINES),
    .GAP_LINES   (GAP_LINES),
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .BEAT_FRAMES (BEAT_FRAMES),
    .PATTERN     (PATTERN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trigger rises and drop pulses are tallied on the falling edge, clear of the sampling point.
  initial begin
    rises     = 0;
    drops     = 0;
    trig_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.snare_trigger && !trig_prev)
        rises++;
      trig_prev = bus.snare_trigger;
      if (bus.event_dropped)
        drops++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int got, input int expected);
    checks_total++;
    if (got !== expected)
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, expected);
    else
      checks_passed++;
  endtask

  task automatic tick();
    bit at_line_start;
    at_line_start = (bus.pix_x == 10'd0);
    @(posedge clk);
    #1;
    if (at_line_start)
      line_count++;
    bus.pix_x = (bus.pix_x == 10'(LINE_LEN - 1)) ? 10'd0 : bus.pix_x + 10'd1;
  endtask

  task automatic applyStimulus(input logic strobe, input logic frame);
    bus.event_strobe = strobe;
    bus.frame_end    = frame;
    tick();
    bus.event_strobe = 1'b0;
    bus.frame_end    = 1'b0;
  endtask

  function automatic logic watched(input int which);
    return (which == 0) ? bus.snare_trigger : bus.busy;
  endfunction

  // which: 0 = snare_trigger, 1 = busy
  task automatic wait_for(input int which, input logic level, input string tag);
    int n;
    n = 0;
    while (watched(which) !== level && n < WAIT_BUDGET) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reached"}, int'(watched(which)), int'(level));
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n;
    n = 0;
    while (rises < target && n < WAIT_BUDGET) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rises_reached"}, (rises >= target) ? 1 : 0, 1);
  endtask

  initial begin
    int r0;
    int d0;
    int hit_pulses[5];
    bit is_hit;

    hit_pulses = '{1, 13, 25, 37, 49};
    checks_total      = 0;
    checks_passed     = 0;
    line_count        = 0;
    bus.event_strobe   = 1'b0;
    bus.pattern_enable = 1'b0;
    bus.frame_end      = 1'b0;
    bus.pix_x          = 10'd0;
    reset              = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_trig",  int'(bus.snare_trigger), 0);
    checkOutput("rst_busy",  int'(bus.busy),          0);
    checkOutput("rst_qc",    int'(bus.queue_count),   0);
    checkOutput("rst_drop",  int'(bus.event_dropped), 0);

    $display("[TB] single hit");
    r0 = rises;
    applyStimulus(1'b1, 1'b0);
    checkOutput("hit_qc_t",   int'(bus.queue_count),   1);
    checkOutput("hit_trig_t", int'(bus.snare_trigger), 0);
    checkOutput("hit_busy_t", int'(bus.busy),          0);
    tick();
    line_count = 0;
    checkOutput("hit_trig_t1", int'(bus.snare_trigger), 1);
    checkOutput("hit_busy_t1", int'(bus.busy),          1);
    checkOutput("hit_qc_t1",   int'(bus.queue_count),   0);
    wait_for(0, 1'b0, "hit_fall");
    checkOutput("hit_hold_lines", line_count, HOLD_LINES);
    wait_for(1, 1'b0, "hit_idle");
    checkOutput("hit_gap_lines", line_count, GAP_LINES);
    checkOutput("hit_qc_end", int'(bus.queue_count), 0);
    tick();
    checkOutput("hit_rises", rises - r0, 1);

    $display("[TB] back-to-back");
    r0 = rises;
    applyStimulus(1'b1, 1'b0);
    tick();
    line_count = 0;
    checkOutput("b2b_trig1", int'(bus.snare_trigger), 1);
    repeat (8) tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("b2b_qc_second", int'(bus.queue_count), 1);
    repeat (9) tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("b2b_qc_peak", int'(bus.queue_count), 2);
    wait_for(1, 1'b0, "b2b_idle1");
    checkOutput("b2b_gap1_lines", line_count, GAP_LINES);
    tick();
    line_count = 0;
    checkOutput("b2b_trig2", int'(bus.snare_trigger), 1);
    checkOutput("b2b_qc2",   int'(bus.queue_count),   1);
    wait_for(1, 1'b0, "b2b_idle2");
    checkOutput("b2b_gap2_lines", line_count, GAP_LINES);
    tick();
    line_count = 0;
    checkOutput("b2b_trig3", int'(bus.snare_trigger), 1);
    checkOutput("b2b_qc3",   int'(bus.queue_count),   0);
    wait_for(1, 1'b0, "b2b_idle3");
    checkOutput("b2b_gap3_lines", line_count, GAP_LINES);
    tick();
    checkOutput("b2b_rises", rises - r0, 3);

    $display("[TB] overflow");
    applyStimulus(1'b1, 1'b0);
    tick();
    wait_for(0, 1'b0, "ovf_fall");
    checkOutput("ovf_qc_pre", int'(bus.queue_count), 0);
    tick();
    r0 = rises;
    d0 = drops;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("ovf_qc",   int'(bus.queue_count),   (i + 1 > QUEUE_DEPTH) ? QUEUE_DEPTH : i + 1);
      checkOutput("ovf_drop", int'(bus.event_dropped), (i >= 4) ? 1 : 0);
    end
    tick();
    checkOutput("ovf_drop_clear", int'(bus.event_dropped), 0);
    checkOutput("ovf_busy_gap",   int'(bus.busy),          1);
    wait_rises(r0 + 4, "ovf");
    wait_for(1, 1'b0, "ovf_idle");
    tick();
    checkOutput("ovf_rises", rises - r0, 4);
    checkOutput("ovf_drops", drops - d0, 2);
    checkOutput("ovf_qc_end", int'(bus.queue_count), 0);

    $display("[TB] pattern");
    r0 = rises;
    bus.pattern_enable = 1'b1;
    for (int p = 1; p <= 49; p++) begin
      is_hit = 1'b0;
      foreach (hit_pulses[k])
        if (hit_pulses[k] == p)
          is_hit = 1'b1;
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("pat_qc_p%0d", p), int'(bus.queue_count), is_hit ? 1 : 0);
      repeat (39) tick();
    end
    wait_for(1, 1'b0, "pat_idle");
    tick();
    checkOutput("pat_rises", rises - r0, 5);
    bus.pattern_enable = 1'b0;
    tick();

    $display("[TB] simultaneous sources");
    r0 = rises;
    bus.pattern_enable = 1'b1;
    applyStimulus(1'b1, 1'b1);
    checkOutput("sim_qc_two",  int'(bus.queue_count),   2);
    checkOutput("sim_trig_lo", int'(bus.snare_trigger), 0);
    tick();
    checkOutput("sim_qc_one",  int'(bus.queue_count),   1);
    checkOutput("sim_trig_hi", int'(bus.snare_trigger), 1);
    wait_rises(r0 + 2, "sim");
    wait_for(1, 1'b0, "sim_idle");
    tick();
    checkOutput("sim_rises",  rises - r0, 2);
    checkOutput("sim_qc_end", int'(bus.queue_count), 0);
    bus.pattern_enable = 1'b0;
    tick();

    $display("[TB] reset mid-operation");
    r0 = rises;
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("mid_trig", int'(bus.snare_trigger), 1);
    checkOutput("mid_qc",   int'(bus.queue_count),   3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_trig", int'(bus.snare_trigger), 0);
    checkOutput("mid_rst_busy", int'(bus.busy),          0);
    checkOutput("mid_rst_qc",   int'(bus.queue_count),   0);
    repeat (200) tick();
    checkOutput("mid_quiet_busy", int'(bus.busy), 0);
    checkOutput("mid_rises",      rises - r0,     1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
